if_fetch_queue: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the 1-cycle-latency instruction BRAM read port.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- A redirect from the branch path flushes buffered and in-flight fetches and restarts fetch at the new target.

---
 rtl/if_pkg.sv | 44 ++++
 rtl/ifq_fifo.sv | 78 +++++++
 rtl/if_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Contents: XLEN/ILEN widths, NOP encoding, the {pc, instr} entry
// carried through the fetch queue, the fetch FSM state type, a constant
// ceil-log2 for pointer widths and a saturating 32-bit add for the
// optional performance counters (IFQ_PERF_COUNTERS_EN).
package if_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RESET = 1'b0,
        FS_RUN   = 1'b1
    } fetch_state_e;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // acc + inc, clamped at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] acc,
                                              input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetch_entry_t used by the fetch queue.
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   clear_i       drop all entries (wins over push/pop)
//   push_i        write push_data_i at the tail
//   pop_i         retire the head entry (caller guarantees count_o != 0)
//   head_o        head entry, valid while count_o != 0
//   count_o       occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (rst && push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC, drives a 1-cycle-latency BRAM read port, buffers
// returned {pc, instr} pairs in ifq_fifo and hands them to decode with
// valid/ready. A redirect flushes buffered and in-flight fetches and
// restarts fetch at the new (word-aligned) target.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   redirect_en, redirect_pc flush and restart at redirect_pc & ~3
//   imem_rd_en, imem_addr    BRAM read strobe / word address
//   imem_data                BRAM data, valid the cycle after imem_rd_en
//   out_valid, out_ready     decode handshake
//   out_pc, out_instr        head entry
//   fetch_pc                 next PC to be issued (debug)
// Optional build macro IFQ_PERF_COUNTERS_EN adds saturating counters:
//   perf_fetched (pushes), perf_flushed (entries + killed responses
//   discarded by redirects), perf_stall (cycles with the queue full).
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_en,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [ILEN-1:0]    out_instr,
`ifdef IFQ_PERF_COUNTERS_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall,
`endif
    output logic [XLEN-1:0]    fetch_pc
);

    localparam int unsigned CNT_W  = clog2(DEPTH + 1);
    localparam int unsigned FREE_W = CNT_W + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              pop;
    logic              push;
    logic              issue;
    logic [FREE_W-1:0] free_slots;

    // Handshake, credit-based issue and kill of the response landing
    // in a redirect cycle. Reset gates everything combinationally.
    always_comb begin
        out_valid  = rst && (count != '0) && !redirect_en;
        pop        = out_valid && out_ready;
        free_slots = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
        issue      = rst && (state_q == FS_RUN) && !redirect_en
                     && (free_slots > FREE_W'(inflight_q));
        push       = inflight_q && !redirect_en;
        push_entry = '{pc: inflight_pc_q, instr: imem_data};
    end

    // Fetch PC / inflight next-state; redirect has priority.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_en) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch FSM and PC/inflight registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FS_RESET;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                FS_RESET: state_q <= FS_RUN;
                FS_RUN:   state_q <= FS_RUN;
            endcase
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (redirect_en),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc_q[IMEM_AW+1:2];
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;
    assign fetch_pc   = fetch_pc_q;

`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= sat_add32(perf_fetched_q, 32'd1);
            end
            if (redirect_en) begin
                perf_flushed_q <= sat_add32(perf_flushed_q,
                                            32'(count) + 32'(inflight_q));
            end
            if (count == CNT_W'(DEPTH)) begin
                perf_stall_q <= sat_add32(perf_stall_q, 32'd1);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboarded bench for if_fetch_queue: every restart (reset or
// redirect) loads the queue of expected {pc, instr} pairs; a negedge
// monitor pops and compares on every accepted output.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned IMEM_AW  = 10;
    localparam int unsigned SEG_LEN  = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               redirect_en;
    logic [31:0]        redirect_pc;
    logic               imem_rd_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [31:0]        out_instr;
    logic [31:0]        fetch_pc;
`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0]        perf_fetched, perf_flushed, perf_stall;
`endif

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .IMEM_AW (IMEM_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
`ifdef IFQ_PERF_COUNTERS_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall  (perf_stall),
`endif
        .fetch_pc   (fetch_pc)
    );

    // Instruction memory contents: word n holds 0x1000_0000 + n.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) % 32'd1024);
    endfunction

    // BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_rd_en === 1'b1) imem_data <= 32'h1000_0000 + 32'(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A restart means decode must next see pc, pc+4, pc+8, ...
    task automatic restart(input logic [31:0] pc);
        fetch_entry_t e;
        logic [31:0]  p;
        exp_q.delete();
        p = pc & ~32'd3;
        for (int i = 0; i < int'(SEG_LEN); i++) begin
            e.pc    = p;
            e.instr = mem_word(p);
            exp_q.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must be the next expected entry.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h with nothing expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int p0;
        int since;
        rst         = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        restart(RESET_PC);

        // Reset state
        tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_rd_en", imem_rd_en, 0);
        chk("reset_fetch_pc", fetch_pc, RESET_PC);

        // Release: first output two cycles after the release edge
        rst = 1'b1;
        tick();
        chk("rel1_rd_en", imem_rd_en, 1);
        chk("rel1_out_valid", out_valid, 0);
        tick();
        chk("rel2_out_valid", out_valid, 0);
        chk("rel2_fetch_pc", fetch_pc, RESET_PC + 32'd4);
        tick();
        chk("rel3_out_valid", out_valid, 1);
        chk("rel3_out_pc", out_pc, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stream_out_valid", out_valid, 1);
        end

        // Back-pressure: queue fills, issue stalls, then drains gap-free
        rst = 1'b0;
        out_ready = 1'b0;
        restart(RESET_PC);
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("full_out_valid", out_valid, 1);
        chk("full_rd_en", imem_rd_en, 0);
        chk("full_fetch_pc", fetch_pc, RESET_PC + 32'h10);
        chk("full_head_pc", out_pc, RESET_PC);
        p0 = pops;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("drain_pops", 32'(pops - p0), 12);
        chk("drain_out_valid", out_valid, 1);

        // Redirect with entries queued and a fetch in flight
        out_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0102;
        restart(32'h0000_0102);
        #1;
        chk("redir_cycle_out_valid", out_valid, 0);
        chk("redir_cycle_rd_en", imem_rd_en, 0);
        tick();
        redirect_en = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("redir1_out_valid", out_valid, 0);
        chk("redir1_fetch_pc", fetch_pc, 32'h0000_0100);
        tick();
        chk("redir2_out_valid", out_valid, 0);
        tick();
        chk("redir3_out_valid", out_valid, 1);
        chk("redir3_out_pc", out_pc, 32'h0000_0100);
        repeat (4) tick();

        // Consecutive redirects: the last one wins
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        restart(32'h0000_0200);
        tick();
        redirect_pc = 32'h0000_0300;
        restart(32'h0000_0300);
        tick();
        redirect_en = 1'b0;
        tick();
        tick();
        chk("dbl_out_valid", out_valid, 1);
        chk("dbl_out_pc", out_pc, 32'h0000_0300);
        repeat (4) tick();

        // PC wrap across 2^32
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        restart(32'hFFFF_FFF8);
        tick();
        redirect_en = 1'b0;
        tick();
        tick();
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFF8);
        chk("wrap_out_instr", out_instr, 32'h1000_03FE);
        tick();
        chk("wrap_out_pc1", out_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_out_pc2", out_pc, 32'h0000_0000);
        tick();
        chk("wrap_out_pc3", out_pc, 32'h0000_0004);
        repeat (3) tick();

        // Reset pulse mid-stream with three entries queued
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_reset_out_valid", out_valid, 1);
        rst = 1'b0;
        restart(RESET_PC);
        #1;
        chk("rst_cycle_out_valid", out_valid, 0);
        chk("rst_cycle_rd_en", imem_rd_en, 0);
        tick();
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_fetch_pc", fetch_pc, RESET_PC);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_rel2_out_valid", out_valid, 0);
        tick();
        chk("mid_rel3_out_pc", out_pc, RESET_PC);
        repeat (4) tick();

        // Random traffic: back-pressure, redirects, occasional resets
        p0 = pops;
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            out_ready   = ($urandom_range(0, 3) != 0);
            rst         = 1'b1;
            redirect_en = 1'b0;
            if (r < 4) begin
                rst = 1'b0;
                restart(RESET_PC);
                since = 0;
            end else if (r < 40 || since > 200) begin
                redirect_en = 1'b1;
                redirect_pc = $urandom();
                restart(redirect_pc);
                since = 0;
            end
            #1;
            if (!rst || redirect_en) begin
                chk("rand_flush_out_valid", out_valid, 0);
                chk("rand_flush_rd_en", imem_rd_en, 0);
            end
            tick();
            since++;
        end
        rst         = 1'b1;
        redirect_en = 1'b0;
        out_ready   = 1'b1;
        repeat (10) tick();
        checks++;
        if (pops - p0 < 1000) begin
            errors++;
            $display("FAIL rand_throughput: got %0d pops expected at least 1000", pops - p0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
